// File: rtl/mem_port_arbiter_if.sv
// Bundle between the CPU fetch/data ports, the arbiter and the single-port SRAM.
// The slave modport is the arbiter's view; the master modport is the core+RAM side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ready;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  ram_ce, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data ports:
// round-robin grant on contention, fixed-length access, one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    // Records the port owning the current/most recent transaction.
    logic              last_grant, last_grant_d;
    logic              grant_data;

    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    // Word-address bits above ADDR_W and the byte offset are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

    assign grant_data = bus.d_req && (!bus.if_req || (last_grant == GNT_IF));

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        last_grant_d = last_grant;
        ram_ce_d     = ram_ce_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    last_grant_d = grant_data ? GNT_D : GNT_IF;
                    cnt_d        = CNT_INIT;
                    ram_ce_d     = 1'b1;
                    state_d      = ST_ACCESS;
                    if (grant_data) begin
                        ram_we_d    = bus.d_we;
                        ram_addr_d  = bus.d_addr[ADDR_W+1:2];
                        ram_wdata_d = bus.d_wdata;
                    end else begin
                        ram_we_d    = 1'b0;
                        ram_addr_d  = bus.if_addr[ADDR_W+1:2];
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    // Read data is only valid in the final access cycle.
                    if (!ram_we_q) begin
                        if (last_grant == GNT_D) begin
                            d_rdata_d = bus.ram_rdata;
                        end else begin
                            if_rdata_d = bus.ram_rdata;
                        end
                    end
                    if (last_grant == GNT_D) begin
                        d_ready_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                    end
                    ram_ce_d = 1'b0;
                    ram_we_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                ram_ce_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_grant  <= GNT_IF;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_grant  <= last_grant_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (WAIT_CYCLES=1 and 3), each with a small SRAM model.
module tb_mem_port_arbiter;
    logic clk;
    logic rst1;
    logic rst3;
    int   n_assert;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(20)) bus1();
    mem_port_arbiter_if #(.ADDR_W(20)) bus3();

    mem_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    mem_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models; known words are reloaded while the matching reset is held.
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];

    always @(posedge clk) begin
        if (rst1) begin
            mem1[10'h100] <= 32'h2408_0005;
            mem1[10'h008] <= 32'hA5A5_0008;
        end else if (bus1.ram_ce && bus1.ram_we) begin
            mem1[bus1.ram_addr[9:0]] <= bus1.ram_wdata;
        end
    end

    always @(posedge clk) begin
        if (rst3) begin
            mem3[10'h040] <= 32'hCAFE_0040;
        end else if (bus3.ram_ce && bus3.ram_we) begin
            mem3[bus3.ram_addr[9:0]] <= bus3.ram_wdata;
        end
    end

    assign bus1.ram_rdata = mem1[bus1.ram_addr[9:0]];
    assign bus3.ram_rdata = mem3[bus3.ram_addr[9:0]];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic exp_d;
        n_assert = 0;
        n_fail   = 0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0;   bus1.d_addr = '0;  bus1.d_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0;
        bus3.d_we = 1'b0;   bus3.d_addr = '0;  bus3.d_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ce",      32'(bus1.ram_ce),    32'h0);
        chk("rst_we",      32'(bus1.ram_we),    32'h0);
        chk("rst_addr",    32'(bus1.ram_addr),  32'h0);
        chk("rst_wdata",   bus1.ram_wdata,      32'h0);
        chk("rst_ready",   32'({bus1.if_ready, bus1.d_ready}), 32'h0);
        chk("rst_if_rd",   bus1.if_rdata,       32'h0);
        chk("rst_d_rd",    bus1.d_rdata,        32'h0);
        chk("rst3_ce",     32'(bus3.ram_ce),    32'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Idle bus.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", 32'({bus1.ram_ce, bus1.ram_we, bus1.if_ready, bus1.d_ready}), 32'h0);
        end

        // Single fetch, WAIT_CYCLES=1.
        bus1.if_addr = 32'h0000_0400;
        bus1.if_req  = 1'b1;
        @(negedge clk);
        chk("fetch_ce",    32'(bus1.ram_ce),   32'h1);
        chk("fetch_addr",  32'(bus1.ram_addr), 32'h100);
        chk("fetch_we",    32'(bus1.ram_we),   32'h0);
        chk("fetch_early", 32'(bus1.if_ready), 32'h0);
        @(negedge clk);
        chk("fetch_ce_off", 32'(bus1.ram_ce),   32'h0);
        chk("fetch_ready",  32'(bus1.if_ready), 32'h1);
        chk("fetch_d_rdy",  32'(bus1.d_ready),  32'h0);
        chk("fetch_rdata",  bus1.if_rdata,      32'h2408_0005);
        bus1.if_req = 1'b0;
        @(negedge clk);
        chk("fetch_pulse",  32'(bus1.if_ready), 32'h0);
        chk("fetch_hold",   bus1.if_rdata,      32'h2408_0005);

        // Data write then read back.
        bus1.d_addr  = 32'h0000_0010;
        bus1.d_wdata = 32'hDEAD_BEEF;
        bus1.d_we    = 1'b1;
        bus1.d_req   = 1'b1;
        @(negedge clk);
        chk("wr_ce",    32'(bus1.ram_ce),   32'h1);
        chk("wr_we",    32'(bus1.ram_we),   32'h1);
        chk("wr_addr",  32'(bus1.ram_addr), 32'h4);
        chk("wr_wdata", bus1.ram_wdata,     32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_we_off", 32'(bus1.ram_we),  32'h0);
        chk("wr_ready",  32'(bus1.d_ready), 32'h1);
        chk("wr_d_rd",   bus1.d_rdata,      32'h0);
        bus1.d_req = 1'b0;
        bus1.d_we  = 1'b0;
        @(negedge clk);
        chk("wr_pulse",  32'(bus1.d_ready), 32'h0);
        bus1.d_wdata = 32'h0;
        bus1.d_req   = 1'b1;
        @(negedge clk);
        chk("rd_ce",   32'(bus1.ram_ce),   32'h1);
        chk("rd_we",   32'(bus1.ram_we),   32'h0);
        chk("rd_addr", 32'(bus1.ram_addr), 32'h4);
        @(negedge clk);
        chk("rd_ready", 32'(bus1.d_ready), 32'h1);
        chk("rd_data",  bus1.d_rdata,      32'hDEAD_BEEF);
        chk("rd_if_rd", bus1.if_rdata,     32'h2408_0005);
        bus1.d_req = 1'b0;
        @(negedge clk);

        // Contention from reset: grants D, IF, D, IF with a 3-cycle period.
        rst1 = 1'b1;
        bus1.if_addr = 32'h0000_0400;
        bus1.d_addr  = 32'h0000_0020;
        bus1.d_we    = 1'b0;
        bus1.if_req  = 1'b1;
        bus1.d_req   = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_d = ((i / 3) % 2) == 0;
            chk("cont_we", 32'(bus1.ram_we), 32'h0);
            if ((i % 3) == 0) begin
                chk("cont_access", 32'({bus1.ram_ce, bus1.d_ready, bus1.if_ready}), 32'h4);
                chk("cont_addr", 32'(bus1.ram_addr), exp_d ? 32'h8 : 32'h100);
            end else if ((i % 3) == 1) begin
                chk("cont_ready", 32'({bus1.ram_ce, bus1.d_ready, bus1.if_ready}),
                    exp_d ? 32'h2 : 32'h1);
                if (exp_d) chk("cont_d_rd", bus1.d_rdata, 32'hA5A5_0008);
                else       chk("cont_if_rd", bus1.if_rdata, 32'h2408_0005);
            end else begin
                chk("cont_idle", 32'({bus1.ram_ce, bus1.d_ready, bus1.if_ready}), 32'h0);
            end
        end
        bus1.if_req = 1'b0;
        bus1.d_req  = 1'b0;
        repeat (2) @(negedge clk);
        chk("cont_quiet", 32'({bus1.ram_ce, bus1.d_ready, bus1.if_ready}), 32'h0);

        // WAIT_CYCLES=3 read with address change after grant.
        bus3.d_addr = 32'h0000_0100;
        bus3.d_we   = 1'b0;
        bus3.d_req  = 1'b1;
        @(negedge clk);
        chk("w3_ce1",   32'(bus3.ram_ce),   32'h1);
        chk("w3_addr1", 32'(bus3.ram_addr), 32'h40);
        bus3.d_addr = 32'h0000_0200;
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            chk("w3_ce",    32'(bus3.ram_ce),   32'h1);
            chk("w3_addr",  32'(bus3.ram_addr), 32'h40);
            chk("w3_early", 32'(bus3.d_ready),  32'h0);
        end
        @(negedge clk);
        chk("w3_ce_off", 32'(bus3.ram_ce),  32'h0);
        chk("w3_ready",  32'(bus3.d_ready), 32'h1);
        chk("w3_rdata",  bus3.d_rdata,      32'hCAFE_0040);
        bus3.d_req = 1'b0;
        @(negedge clk);
        chk("w3_pulse",  32'(bus3.d_ready), 32'h0);

        // Reset during the second access cycle of a write.
        bus3.d_addr  = 32'h0000_0300;
        bus3.d_wdata = 32'h1234_5678;
        bus3.d_we    = 1'b1;
        bus3.d_req   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_pre", 32'({bus3.ram_ce, bus3.ram_we}), 32'h3);
        rst3 = 1'b1;
        bus3.d_req = 1'b0;
        bus3.d_we  = 1'b0;
        @(negedge clk);
        chk("abort_ram", 32'({bus3.ram_ce, bus3.ram_we}), 32'h0);
        chk("abort_rdy", 32'(bus3.d_ready), 32'h0);
        rst3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({bus3.ram_ce, bus3.ram_we, bus3.d_ready}), 32'h0);
        end
        bus3.d_addr = 32'h0000_0100;
        bus3.d_req  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rep_ce",    32'(bus3.ram_ce),  32'h1);
        chk("rep_early", 32'(bus3.d_ready), 32'h0);
        @(negedge clk);
        chk("rep_ready", 32'(bus3.d_ready), 32'h1);
        chk("rep_rdata", bus3.d_rdata,      32'hCAFE_0040);
        bus3.d_req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-port synchronous SRAM between the pipeline's instruction-fetch port and its data-memory port. It sits between the CPU core and the board RAM, serialises the two requesters into fixed-length RAM transactions, and returns each result with a one-cycle ready pulse. The pipeline holds IF/MEM until the matching ready pulse arrives.

## Interface
- ADDR_W, 20: RAM word-address width; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1: RAM access cycles per transaction; legal range 1..7.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request; held high until if_ready.
- if_addr  in  32  byte address of the fetch; bits [1:0] ignored.
- if_rdata  out  32  fetched word; valid in the if_ready cycle and held until the next fetch completes.
- if_ready  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wdata  in  32  write data.
- d_rdata  out  32  read word; valid in the d_ready cycle and held until the next data read completes.
- d_ready  out  1  one-cycle pulse: data access complete.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address = req_addr[ADDR_W+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid during the final access cycle.

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: sample requests. No request: stay in IDLE. One request: grant it. Both pending: grant the requester that was not granted last (last_grant register). Go to ACCESS with cnt = WAIT_CYCLES-1.
- ACCESS: ram_ce=1. ram_addr, ram_we (=d_we for a data grant, 0 for a fetch) and ram_wdata are latched at grant and held constant. If cnt != 0, decrement. If cnt == 0 and the transaction is a read, capture ram_rdata into if_rdata or d_rdata; then go to DONE.
- DONE: ram_ce=0, ram_we=0. Assert the granted port's ready for exactly this cycle, then go to IDLE. Requests are not re-arbitrated in DONE.
- A write never changes d_rdata. A fetch never changes d_rdata, and a data access never changes if_rdata.
- Request and address fields are latched at grant. Changes on the inputs after the grant do not affect the transaction in flight.
- If a request drops mid-transaction (protocol violation), the transaction still completes and the ready pulse is still issued.
- Reset values: state=IDLE, last_grant=IF (so data wins the first tie), cnt=0, ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
- Reset mid-transaction: in the next cycle ram_ce and ram_we are 0, no ready pulse is issued, and the aborted request must be re-presented.

## Timing
- Request seen in IDLE at edge N: ACCESS occupies cycles N+1 .. N+WAIT_CYCLES; ready is high in cycle N+WAIT_CYCLES+1.
- Request-to-ready latency = WAIT_CYCLES+1 cycles after the sampling edge.
- Transaction period = WAIT_CYCLES+2 cycles, since IDLE costs one cycle. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- The requester may deassert its request in the ready cycle. A request still high in the cycle after ready is treated as a new request.
- Both requests pending continuously: grants alternate D, IF, D, IF, ... starting with D after reset.
- ram_we is high only in ACCESS cycles, so no write strobe leaks into IDLE or DONE.

## Test plan
- Single fetch, WAIT_CYCLES=1, RAM word 0x100 = 0x24080005, if_addr=0x00000400 → ram_addr=0x100 and ram_ce=1 for 1 cycle; if_ready pulses 2 cycles after the sampling edge with if_rdata=0x24080005.
- Data write then read, d_addr=0x00000010: write 0xDEADBEEF → ram_we=1 for exactly WAIT_CYCLES cycles at ram_addr=0x4; d_rdata unchanged. Then read → d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held high from reset for 4 transactions → grant order D, IF, D, IF; each ready pulse is one cycle; d_ready and if_ready are never high together.
- WAIT_CYCLES=3: single read → ram_ce high for 3 consecutive cycles; ready arrives 4 cycles after the sampling edge; ram_addr stable throughout even when d_addr changes after the grant.
- Reset asserted in the 2nd ACCESS cycle of a write (WAIT_CYCLES=3) → next cycle ram_we=0, ram_ce=0, no d_ready; after release, a re-presented read completes normally.
- Idle bus, no requests for 10 cycles → ram_ce=0, ram_we=0, and both ready outputs stay 0.
